// File: rtl/eyeriss_glb_pkg.sv
// -----------------------------------------------------------------------------
// eyeriss_glb_pkg
// Shared definitions for the global buffer (GLB) banks and the blocks that
// load or drain them.
//   GLB_BANK_DEPTH / GLB_ADDR_BW / GLB_DATA_BW : psum bank geometry
//   drain_state_t                              : psum drain controller states
// -----------------------------------------------------------------------------
package eyeriss_glb_pkg;

  localparam int GLB_BANK_DEPTH = 8192;
  localparam int GLB_ADDR_BW    = 13;
  localparam int GLB_DATA_BW    = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } drain_state_t;

endpackage

// File: rtl/glb_psum_drain_if.sv
// -----------------------------------------------------------------------------
// glb_psum_drain_if
// Valid/ready word stream from the psum drain towards the host/DMA side.
//   data  : stream word
//   valid : word present
//   ready : sink accepts the word this cycle
//   last  : final word of the region
// Modports: master (drain side), slave (sink side).
// -----------------------------------------------------------------------------
interface glb_psum_drain_if #(
  parameter int DATA_BW = eyeriss_glb_pkg::GLB_DATA_BW
);
  logic [DATA_BW-1:0] data;
  logic               valid;
  logic               ready;
  logic               last;

  modport master (output data, output valid, output last, input ready);
  modport slave  (input data, input valid, input last, output ready);
endinterface

// File: rtl/glb_psum_drain_fifo2.sv
// -----------------------------------------------------------------------------
// drain_fifo2
// Two-entry synchronous FIFO that buffers psum words between the bank read
// port and the output stream. Entry 0 is always the head, so the head value
// stays put while the sink stalls.
//   i_clk, i_rst : clock, synchronous active-high reset
//   i_push/i_data: write a word (dropped if full and not popping)
//   i_pop        : remove the head (ignored when empty)
//   o_count      : occupancy 0..2
//   o_head       : current head word
// -----------------------------------------------------------------------------
module drain_fifo2 #(
  parameter int DATA_BW = 32
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_push,
  input  logic [DATA_BW-1:0] i_data,
  input  logic               i_pop,
  output logic [1:0]         o_count,
  output logic [DATA_BW-1:0] o_head
);

  logic [DATA_BW-1:0] r_mem0;
  logic [DATA_BW-1:0] r_mem1;
  logic [1:0]         r_count;
  logic               w_pop;
  logic               w_push;

  assign w_pop  = i_pop && (r_count != 2'd0);
  assign w_push = i_push && ((r_count != 2'd2) || w_pop);

  // NOTE: the two storage words are reset (not just the count) because the
  // head drives a block output that must read 0 straight out of reset.
  // NOTE: state is updated with non-blocking assignments so every branch
  // below sees the pre-edge values of r_mem0/r_mem1/r_count.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= 2'd0;
      r_mem0  <= '0;
      r_mem1  <= '0;
    end else begin
      case ({w_push, w_pop})
        2'b10: begin
          if (r_count == 2'd0) r_mem0 <= i_data;
          else                 r_mem1 <= i_data;
          r_count <= r_count + 2'd1;
        end
        2'b01: begin
          r_mem0  <= r_mem1;
          r_count <= r_count - 2'd1;
        end
        2'b11: begin
          // Occupancy unchanged: the new word lands behind the surviving one.
          if (r_count == 2'd1) begin
            r_mem0 <= i_data;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign o_count = r_count;
  assign o_head  = r_mem0;

endmodule

// File: rtl/glb_psum_drain.sv
// -----------------------------------------------------------------------------
// glb_psum_drain
// Drains a contiguous psum region out of the GLB psum bank after the core is
// done and streams it out over a valid/ready interface. The block drives the
// bank port only while o_busy is high; otherwise the core owns it.
//   i_clk, i_rst        : clock, synchronous active-high reset (aborts a drain)
//   i_start             : 1-cycle start pulse, honoured only when idle
//   i_base_addr         : first word address (wraps modulo BANK_DEPTH)
//   i_num_elem          : word count (0 = no bank access, just o_done)
//   o_busy / o_done     : drain in progress / 1-cycle completion pulse
//   o_bram_*            : psum bank port (1-cycle read latency)
//   i_bram_rdata        : bank read data
//   io_stream (master)  : data / valid / ready / last output stream
// Build option: define PSUM_DRAIN_CLEAR_EN to write 0 back to every address
// in the cycle after it is read, leaving the region zeroed for the next layer.
// -----------------------------------------------------------------------------
module glb_psum_drain
  import eyeriss_glb_pkg::*;
#(
  parameter int BANK_DEPTH    = GLB_BANK_DEPTH,
  parameter int DATA_BITWIDTH = GLB_DATA_BW,
  parameter int ADDR_BITWIDTH = GLB_ADDR_BW
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_start,
  input  logic [ADDR_BITWIDTH-1:0] i_base_addr,
  input  logic [ADDR_BITWIDTH:0]   i_num_elem,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_bram_en,
  output logic                     o_bram_we,
  output logic [ADDR_BITWIDTH-1:0] o_bram_addr,
  output logic [DATA_BITWIDTH-1:0] o_bram_wdata,
  input  logic [DATA_BITWIDTH-1:0] i_bram_rdata,
  glb_psum_drain_if.master         io_stream
);

  drain_state_t               r_state, w_next;
  logic [ADDR_BITWIDTH-1:0]   r_addr;      // next read address
  logic [ADDR_BITWIDTH:0]     r_num;       // words in this drain
  logic [ADDR_BITWIDTH:0]     r_issued;    // reads issued so far
  logic [ADDR_BITWIDTH:0]     r_popped;    // words handshaked so far
  logic                       r_pending;   // read issued last cycle, data returns now

  logic [ADDR_BITWIDTH-1:0]   w_addr_next;
  logic [1:0]                 w_fifo_count;
  logic [DATA_BITWIDTH-1:0]   w_head;
  logic                       w_valid;
  logic                       w_pop;
  logic                       w_last_hs;
  logic [2:0]                 w_occ;
  logic                       w_room;
  logic                       w_issue;
  logic                       w_clr;
  logic [ADDR_BITWIDTH-1:0]   w_clr_addr;

  assign w_addr_next = (r_addr == ADDR_BITWIDTH'(BANK_DEPTH - 1)) ? '0 : r_addr + 1'b1;

  assign w_valid   = (w_fifo_count != 2'd0);
  assign w_pop     = w_valid && io_stream.ready;
  assign w_last_hs = w_pop && (r_popped == r_num - 1'b1);

  // Words held plus words on their way must stay below 2. A pop in this
  // cycle frees a slot before the new read can land, which is what keeps the
  // stream at one word per cycle while the sink is always ready.
  assign w_occ  = {1'b0, w_fifo_count} + {2'b00, r_pending};
  assign w_room = w_occ < (3'd2 + {2'b00, w_pop});

`ifdef PSUM_DRAIN_CLEAR_EN
  logic                     r_clr;
  logic [ADDR_BITWIDTH-1:0] r_clr_addr;

  // Each read is followed by a zero write to the same address, so reads
  // and clears alternate on the single bank port.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_clr      <= 1'b0;
      r_clr_addr <= '0;
    end else begin
      r_clr <= w_issue;
      if (w_issue) r_clr_addr <= r_addr;
    end
  end

  assign w_clr      = r_clr;
  assign w_clr_addr = r_clr_addr;
`else
  assign w_clr      = 1'b0;
  assign w_clr_addr = '0;
`endif

  // NOTE: every signal driven here gets its default first, so no path through
  // the case statement can leave one unassigned and infer a latch.
  always_comb begin
    w_next  = r_state;
    w_issue = 1'b0;
    case (r_state)
      IDLE: begin
        if (i_start) w_next = (i_num_elem == '0) ? DONE : RUN;
      end
      RUN: begin
        w_issue = (r_issued != r_num) && !w_clr && w_room;
        if (w_last_hs)                             w_next = DONE;
        else if ((r_issued == r_num) && !w_clr)    w_next = FLUSH;
      end
      FLUSH: begin
        if (w_last_hs) w_next = DONE;
      end
      DONE:    w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_addr    <= '0;
      r_num     <= '0;
      r_issued  <= '0;
      r_popped  <= '0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_pending <= w_issue;
      if ((r_state == IDLE) && i_start) begin
        r_addr   <= i_base_addr;
        r_num    <= i_num_elem;
        r_issued <= '0;
        r_popped <= '0;
      end else begin
        if (w_issue) begin
          r_addr   <= w_addr_next;
          r_issued <= r_issued + 1'b1;
        end
        if (w_pop) r_popped <= r_popped + 1'b1;
      end
    end
  end

  drain_fifo2 #(.DATA_BW(DATA_BITWIDTH)) u_fifo (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_push  (r_pending),
    .i_data  (i_bram_rdata),
    .i_pop   (w_pop),
    .o_count (w_fifo_count),
    .o_head  (w_head)
  );

  assign o_busy       = (r_state != IDLE);
  assign o_done       = (r_state == DONE);
  assign o_bram_en    = w_issue || w_clr;
  assign o_bram_we    = w_clr;
  assign o_bram_addr  = w_clr ? w_clr_addr : (w_issue ? r_addr : '0);
  assign o_bram_wdata = '0;

  assign io_stream.valid = w_valid;
  assign io_stream.data  = w_head;
  // The head is word number r_popped, so last is stable across stalls.
  assign io_stream.last  = w_valid && (r_popped == r_num - 1'b1);

endmodule
